// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
//   NIB_W / SEG_W : nibble and segment-bus widths
//   SEG_OFF       : active-high "all segments dark" pattern
//   HEX_SEG       : hex nibble -> active-high gfedcba segment table
//   digit_idx_t   : digit index for the default 4-digit display
package sseg_pkg;

  localparam int unsigned NUM_DIGITS_DEF = 4;
  localparam int unsigned NIB_W          = 4;
  localparam int unsigned SEG_W          = 7;

  typedef logic [$clog2(NUM_DIGITS_DEF)-1:0] digit_idx_t;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

  // Entry 15 first: F, E, d, C, b, A, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0
  localparam logic [15:0][SEG_W-1:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// CPU-side load channel of the scan controller.
//   data_in    : hex value, nibble 0 = rightmost digit
//   data_valid : data_in offered this cycle
//   data_ready : controller can take data_in this cycle
//   blank_lz   : leading-zero blanking request, travels with data_in
interface sseg_scan_ctrl_if
  import sseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
);

  logic [NIB_W*NUM_DIGITS-1:0] data_in;
  logic                        data_valid;
  logic                        data_ready;
  logic                        blank_lz;

  modport master (output data_in, output data_valid, output blank_lz, input data_ready);
  modport slave  (input data_in, input data_valid, input blank_lz, output data_ready);

endinterface

// File: rtl/hex7seg.sv
// Hex nibble to active-high seven-segment decoder (purely combinational).
//   nib_i   : 4-bit hex digit
//   seg_o_c : segments gfedcba, 1 = lit
module hex7seg
  import sseg_pkg::*;
(
  input  logic [NIB_W-1:0] nib_i,
  output logic [SEG_W-1:0] seg_o_c
);

  assign seg_o_c = HEX_SEG[nib_i];

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment display driver. One digit is shown per rising
// edge of the sampled scan reference sclk_i; a new value loaded over the bus
// is buffered and only swapped in at a frame boundary.
//   clk, rst_n : system clock, asynchronous active-low reset
//   sclk_i     : slow scan reference, sampled as data (synchronous to clk)
//   bus        : load channel (data_in/data_valid/data_ready/blank_lz)
//   seg_o      : segment drive gfedcba, polarity set by SEG_ACTIVE_LOW
//   an_o       : one-hot digit enable, polarity set by SEG_ACTIVE_LOW
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk_i,
  sseg_scan_ctrl_if.slave       bus,
  output logic [SEG_W-1:0]      seg_o,
  output logic [NUM_DIGITS-1:0] an_o
);

  localparam int unsigned DW    = NIB_W * NUM_DIGITS;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SEG_W-1:0]      SEG_RST  = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [NUM_DIGITS-1:0] AN_RST   = {NUM_DIGITS{SEG_ACTIVE_LOW}};

  logic                  sclk_q;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DW-1:0]         disp_q, disp_d;
  logic [DW-1:0]         pend_q, pend_d;
  logic                  pend_full_q, pend_full_d;
  logic                  pend_lz_q, pend_lz_d;
  logic                  lz_q, lz_d;
  logic                  ready_q, ready_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                  tick_c;
  logic                  accept_c;
  logic [NIB_W-1:0]      nib_c;
  logic [SEG_W-1:0]      seg_hex_c;
  logic                  upper_zero_c;
  logic                  blank_c;
  logic [NUM_DIGITS-1:0] an_hot_c;
  logic [SEG_W-1:0]      seg_pos_c;

  // One-cycle pulse per sclk rising edge
  assign tick_c   = sclk_i & ~sclk_q;
  assign accept_c = bus.data_valid & ready_q;

  // Current digit selection and leading-zero detection
  always_comb begin
    nib_c        = disp_q[NIB_W*idx_q +: NIB_W];
    upper_zero_c = ((disp_q >> (NIB_W*idx_q)) == '0);
    blank_c      = lz_q & (idx_q != '0) & upper_zero_c;
    an_hot_c     = NUM_DIGITS'(1) << idx_q;
  end

  hex7seg u_hex7seg (
    .nib_i   (nib_c),
    .seg_o_c (seg_hex_c)
  );

  // Next-state: buffer load, scan step, frame-end commit
  always_comb begin
    idx_d       = idx_q;
    disp_d      = disp_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    pend_lz_d   = pend_lz_q;
    lz_d        = lz_q;
    seg_d       = seg_q;
    an_d        = an_q;
    seg_pos_c   = blank_c ? SEG_OFF : seg_hex_c;

    // accept and commit are exclusive: accept needs an empty buffer
    if (accept_c) begin
      pend_d      = bus.data_in;
      pend_lz_d   = bus.blank_lz;
      pend_full_d = 1'b1;
    end

    if (tick_c) begin
      seg_d = SEG_ACTIVE_LOW ? ~seg_pos_c : seg_pos_c;
      an_d  = SEG_ACTIVE_LOW ? ~an_hot_c  : an_hot_c;
      if (idx_q == LAST_IDX) begin
        idx_d = '0;
        // Swap only at frame end so a frame never mixes two values
        if (pend_full_q) begin
          disp_d      = pend_q;
          lz_d        = pend_lz_q;
          pend_full_d = 1'b0;
        end
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    ready_d = ~pend_full_d;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q      <= 1'b0;
      idx_q       <= '0;
      disp_q      <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      pend_lz_q   <= 1'b0;
      lz_q        <= 1'b0;
      ready_q     <= 1'b1;
      seg_q       <= SEG_RST;
      an_q        <= AN_RST;
    end else begin
      sclk_q      <= sclk_i;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      pend_lz_q   <= pend_lz_d;
      lz_q        <= lz_d;
      ready_q     <= ready_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign seg_o          = seg_q;
  assign an_o           = an_q;
  assign bus.data_ready = ready_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Scoreboard bench for sseg_scan_ctrl (4 digits, active-low drive).
// Stimulus pushes the expected {an,seg} for each sclk rise; a monitor pops
// and compares whenever the registered display outputs change.
module tb_sseg_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       sclk;
  logic [6:0] seg;
  logic [3:0] an;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [10:0] exp_q[$];
  time         last_step_t = 0;
  time         commit_a_t  = 0;
  time         acc_t       = 0;

  sseg_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

  sseg_scan_ctrl #(
    .NUM_DIGITS     (4),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sclk_i (sclk),
    .bus    (bus),
    .seg_o  (seg),
    .an_o   (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: every display change must match the next queued expectation
  initial begin : monitor
    logic [10:0] prev_out;
    logic [10:0] cur;
    logic [10:0] e;
    prev_out = '0;
    forever begin
      @(negedge clk);
      #1;
      cur = {an, seg};
      if (!rst_n) begin
        prev_out = cur;
      end else if (cur !== prev_out) begin
        prev_out = cur;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_step: got an=%h seg=%h, required no change", cur[10:7], cur[6:0]);
        end else begin
          e = exp_q.pop_front();
          chk("scan_out{an,seg}", 32'(cur), 32'(e));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  // One sclk pulse (2 clk high, 2 clk low); output must follow one clk later
  task automatic step(input logic [3:0] ean, input logic [6:0] eseg);
    last_step_t = $time;
    exp_q.push_back({ean, eseg});
    sclk = 1'b1;
    @(negedge clk);
    #2;
    chk("latency_queue_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    sclk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic frame(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3);
    step(4'hE, s0);
    step(4'hD, s1);
    step(4'hB, s2);
    step(4'h7, s3);
  endtask

  // Single-cycle offer followed by junk data that must be ignored
  task automatic offer(input logic [15:0] d, input logic lz);
    chk("ready_before_offer", 32'(bus.data_ready), 32'd1);
    bus.data_valid = 1'b1;
    bus.data_in    = d;
    bus.blank_lz   = lz;
    @(negedge clk);
    bus.data_valid = 1'b0;
    bus.data_in    = 16'h8888;
    bus.blank_lz   = 1'b0;
    chk("ready_low_after_offer", 32'(bus.data_ready), 32'd0);
  endtask

  initial begin : stim
    rst_n          = 1'b0;
    sclk           = 1'b0;
    bus.data_valid = 1'b0;
    bus.data_in    = '0;
    bus.blank_lz   = 1'b0;

    // 1: reset holds outputs dark while sclk toggles
    repeat (6) begin
      @(negedge clk);
      sclk = ~sclk;
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_ready", 32'(bus.data_ready), 32'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_seg", 32'(seg), 32'h7F);
    frame(7'h40, 7'h40, 7'h40, 7'h40);

    // 2: 0x12AF without blanking, committed at frame end
    offer(16'h12AF, 1'b0);
    step(4'hE, 7'h40);
    step(4'hD, 7'h40);
    step(4'hB, 7'h40);
    chk("ready_low_until_frame_end", 32'(bus.data_ready), 32'd0);
    step(4'h7, 7'h40);
    chk("ready_after_commit", 32'(bus.data_ready), 32'd1);
    frame(7'h0E, 7'h08, 7'h24, 7'h79);

    // 3: leading-zero blanking
    offer(16'h0005, 1'b1);
    frame(7'h0E, 7'h08, 7'h24, 7'h79);
    offer(16'h0000, 1'b1);
    frame(7'h12, 7'h7F, 7'h7F, 7'h7F);
    offer(16'h0105, 1'b1);
    frame(7'h40, 7'h7F, 7'h7F, 7'h7F);
    frame(7'h12, 7'h40, 7'h79, 7'h7F);

    // 4: back-to-back offers with valid held high
    fork
      begin : driver
        bus.data_valid = 1'b1;
        bus.data_in    = 16'h1111;
        bus.blank_lz   = 1'b0;
        @(negedge clk);
        bus.data_in = 16'h2222;
        for (int n = 0; n < 400 && acc_t == 0; n++) begin
          if (bus.data_ready) acc_t = $time;
          else @(negedge clk);
        end
        @(negedge clk);
        bus.data_valid = 1'b0;
        bus.data_in    = 16'h8888;
      end
      begin : scanner
        repeat (2) @(negedge clk);
        chk("ready_low_while_buffered", 32'(bus.data_ready), 32'd0);
        frame(7'h12, 7'h40, 7'h79, 7'h7F);
        commit_a_t = last_step_t;
        frame(7'h79, 7'h79, 7'h79, 7'h79);
        frame(7'h24, 7'h24, 7'h24, 7'h24);
      end
    join
    chk("second_accept_one_cycle_after_commit", 32'(acc_t - commit_a_t), 32'd10);

    // 5: a long sclk high is one step; its fall is none
    exp_q.push_back({4'hE, 7'h24});
    sclk = 1'b1;
    @(negedge clk);
    #2;
    chk("long_high_latency", 32'(exp_q.size()), 32'd0);
    repeat (9) @(negedge clk);
    sclk = 1'b0;
    repeat (10) @(negedge clk);
    chk("long_high_hold", 32'({an, seg}), 32'({4'hE, 7'h24}));

    // 6: reset mid-frame with a pending value
    step(4'hD, 7'h24);
    offer(16'h3333, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_seg", 32'(seg), 32'h7F);
    chk("midrst_an", 32'(an), 32'hF);
    chk("midrst_ready", 32'(bus.data_ready), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready_after_release", 32'(bus.data_ready), 32'd1);
    frame(7'h40, 7'h40, 7'h40, 7'h40);
    frame(7'h40, 7'h40, 7'h40, 7'h40);

    repeat (5) @(negedge clk);
    chk("queue_empty_at_end", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
